// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline-stage definitions: load opcodes, occupancy
//               encoding and the opcode-field slice helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Widest instruction the opcode helper can slice
    localparam int INSTR_MAX_W = 64;

    // Opcodes that return memory data to the register file
    localparam logic [3:0] OP_LW = 4'b0110;
    localparam logic [3:0] OP_LB = 4'b0100;

    // Occupancy of a two-slot (head + skid) pipeline register
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    // Returns the 4-bit opcode held in the top nibble of an instruction of
    // width instr_w, which the caller zero-extends to INSTR_MAX_W bits.
    function automatic logic [3:0] op_field(
        input logic [INSTR_MAX_W-1:0] instr,
        input int unsigned            instr_w
    );
        logic [INSTR_MAX_W-1:0] w_shifted;
        w_shifted = instr >> (instr_w - 4);
        return w_shifted[3:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module      : pipe_slot
// Description : One storage slot of a pipeline register: a valid bit plus a
//               flat payload register with load and clear controls. Clear
//               only drops the valid bit; payload keeps its stale contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
    parameter int PAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [PAY_W-1:0] pay_i,
    output logic             valid_o,
    output logic [PAY_W-1:0] pay_o
);

    logic             valid_q;
    logic             valid_d;
    logic [PAY_W-1:0] pay_q;
    logic [PAY_W-1:0] pay_d;

    // Load wins over clear; clear leaves payload untouched
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (load_i) begin
            valid_d = 1'b1;
            pay_d   = pay_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register; reset zeroes payload so outputs read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o = valid_q;
    assign pay_o   = pay_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
// ============================================================================
// Module      : mem_wb_pipe_reg
// Description : MEM->WB pipeline register with valid/ready handshake, a
//               two-entry (head + skid) buffer, writeback-value selection at
//               capture and a one-away forwarding port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int         INSTR_W  = 16,
    parameter int         DATA_W   = 32,
    parameter int         MEM_W    = 16,
    parameter int         RD_LSB   = 8,
    parameter int         RD_W     = 4,
    parameter logic [3:0] LOAD_OP0 = OP_LW,
    parameter logic [3:0] LOAD_OP1 = OP_LB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [DATA_W-1:0]  alu_in,
    input  logic [MEM_W-1:0]   rdata_in,
    input  logic               wb_en_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [DATA_W-1:0]  alu_out,
    output logic [MEM_W-1:0]   rdata_out,
    output logic               wb_en_out,
    output logic [DATA_W-1:0]  wb_data,
    output logic               fwd_valid,
    output logic [RD_W-1:0]    fwd_rd,
    output logic [DATA_W-1:0]  fwd_data
);

    // Payload layout: {instr, alu, rdata, wb_en, wb_data}
    localparam int PAY_W = INSTR_W + DATA_W + MEM_W + 1 + DATA_W;

    occ_e state_q;
    occ_e state_d;

    logic                   w_accept;
    logic                   w_pop;
    logic                   h_load;
    logic                   h_clear;
    logic                   h_from_s;
    logic                   s_load;
    logic                   s_clear;
    logic                   h_valid;
    logic                   s_valid;
    logic                   w_h_wb_en;
    logic [INSTR_MAX_W-1:0] w_instr_ext;
    logic [3:0]             w_op;
    logic [DATA_W-1:0]      w_wb_sel;
    logic [PAY_W-1:0]       w_in_pay;
    logic [PAY_W-1:0]       w_h_din;
    logic [PAY_W-1:0]       w_h_pay;
    logic [PAY_W-1:0]       w_s_pay;

    // Writeback value chosen once, at capture, and stored with the entry
    always_comb begin
        w_instr_ext                = '0;
        w_instr_ext[INSTR_W-1:0]   = instr_in;
        w_op                       = op_field(w_instr_ext, INSTR_W);
        if ((w_op == LOAD_OP0) || (w_op == LOAD_OP1)) begin
            w_wb_sel = DATA_W'(rdata_in);
        end else begin
            w_wb_sel = alu_in;
        end
    end

    assign w_in_pay = {instr_in, alu_in, rdata_in, wb_en_in, w_wb_sel};

    // in_ready comes straight from the skid valid register, so there is no
    // combinational path from out_ready back to the MEM stage.
    assign in_ready = ~s_valid;
    assign w_accept = in_valid & in_ready & ~flush;
    assign w_pop    = h_valid & out_ready;

    // Occupancy next-state and slot load/clear controls; flush beats all
    always_comb begin
        state_d  = state_q;
        h_load   = 1'b0;
        h_clear  = 1'b0;
        h_from_s = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (flush) begin
            h_clear = 1'b1;
            s_clear = 1'b1;
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        h_load  = 1'b1;
                        state_d = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_pop) begin
                        if (w_accept) begin
                            h_load = 1'b1;
                        end else begin
                            h_clear = 1'b1;
                            state_d = ST_EMPTY;
                        end
                    end else if (w_accept) begin
                        s_load  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Skid is occupied so nothing can be accepted this cycle
                    if (w_pop) begin
                        h_load   = 1'b1;
                        h_from_s = 1'b1;
                        s_clear  = 1'b1;
                        state_d  = ST_HEAD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign w_h_din = h_from_s ? w_s_pay : w_in_pay;

    pipe_slot #(
        .PAY_W   (PAY_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .load_i  (h_load),
        .clear_i (h_clear),
        .pay_i   (w_h_din),
        .valid_o (h_valid),
        .pay_o   (w_h_pay)
    );

    pipe_slot #(
        .PAY_W   (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (s_load),
        .clear_i (s_clear),
        .pay_i   (w_in_pay),
        .valid_o (s_valid),
        .pay_o   (w_s_pay)
    );

    assign {instr_out, alu_out, rdata_out, w_h_wb_en, wb_data} = w_h_pay;

    assign out_valid = h_valid;
    assign wb_en_out = h_valid & w_h_wb_en;
    assign fwd_valid = out_valid & wb_en_out;
    assign fwd_rd    = instr_out[RD_LSB +: RD_W];
    assign fwd_data  = wb_data;

endmodule

`default_nettype wire
